// File: rtl/reg_ctrl_sequencer_pkg.sv
// Shared definitions for the register-bank control sequencer: phase encodings,
// opcode constants and instruction field positions.
package reg_ctrl_sequencer_pkg;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_WB     = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_ST   = 4'hD;
    localparam logic [3:0] OP_RSVD = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction layout: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6
    localparam int OP_LSB  = 12;
    localparam int OP_W    = 4;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_W   = 6;

endpackage

// File: rtl/reg_ctrl_sequencer_decode.sv
// Combinational field extraction and opcode classification for the held
// instruction word.
module instr_decode
    import reg_ctrl_sequencer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic [DATA_W-1:0] ir,
    output logic [OP_W-1:0]   op,
    output logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [DATA_W-1:0] imm,
    output logic              writes_rd,
    output logic              is_branch,
    output logic              is_halt
);

    assign op  = ir[OP_LSB +: OP_W];
    assign rd  = ir[RD_LSB +: REG_AW];
    assign rs1 = ir[RS1_LSB +: REG_AW];
    assign rs2 = ir[RS2_LSB +: REG_AW];
    assign imm = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

    // Only ops 1..B produce a register result; NOP, branch, store, reserved and halt do not.
    assign writes_rd = (op != OP_NOP) && (op < OP_BR);
    assign is_branch = (op == OP_BR);
    assign is_halt   = (op == OP_HALT);

endmodule

// File: rtl/reg_ctrl_sequencer.sv
// Fetch/decode/writeback sequencer driving the register bank phase, write
// strobe and source select; owns the PC.
//
// state    | meaning
// S_FETCH  | imem_req high, wait for imem_valid, capture IR
// S_DECODE | rf_sel=rs1, alu_op/imm presented, no write
// S_WB     | rf_sel=rs2, rf_enable=rd for writing ops, PC update
// S_HALT   | halted, no fetch, held until reset
module reg_ctrl_sequencer
    import reg_ctrl_sequencer_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter int                REG_AW   = 3,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [1:0]        rf_state,
    output logic [REG_AW-1:0] rf_enable,
    output logic [REG_AW-1:0] rf_sel,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] imm,
    output logic              halted
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic [DATA_W-1:0]   ir, ir_nxt;

    logic [OP_W-1:0]     dec_op;
    logic [REG_AW-1:0]   dec_rd, dec_rs1, dec_rs2;
    logic [DATA_W-1:0]   dec_imm;
    logic                dec_writes_rd, dec_is_branch, dec_is_halt;

    // Decoding the next IR lets the phase outputs be registered on the same
    // edge that enters the phase, so they are stable for the whole phase.
    instr_decode #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_decode (
        .ir        (ir_nxt),
        .op        (dec_op),
        .rd        (dec_rd),
        .rs1       (dec_rs1),
        .rs2       (dec_rs2),
        .imm       (dec_imm),
        .writes_rd (dec_writes_rd),
        .is_branch (dec_is_branch),
        .is_halt   (dec_is_halt)
    );

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        case (state)
            S_FETCH: begin
                if (imem_valid) begin
                    ir_nxt    = imem_data;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: state_nxt = S_WB;
            S_WB: begin
                if (dec_is_halt) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_FETCH;
                    pc_nxt    = (dec_is_branch && branch_taken) ? branch_target : pc + 1'b1;
                end
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            imem_req  <= 1'b0;
            rf_enable <= '0;
            rf_sel    <= '0;
            alu_op    <= '0;
            imm       <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            ir       <= ir_nxt;
            imem_req <= (state_nxt == S_FETCH);
            case (state_nxt)
                S_DECODE: begin
                    rf_sel    <= dec_rs1;
                    rf_enable <= '0;
                    alu_op    <= dec_op;
                    imm       <= dec_imm;
                end
                S_WB: begin
                    rf_sel    <= dec_rs2;
                    rf_enable <= dec_writes_rd ? dec_rd : '0;
                    alu_op    <= dec_op;
                    imm       <= dec_imm;
                end
                default: begin
                    rf_sel    <= '0;
                    rf_enable <= '0;
                    alu_op    <= '0;
                    imm       <= '0;
                end
            endcase
        end
    end

    assign imem_addr = pc;
    assign rf_state  = state;
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_reg_ctrl_sequencer.sv
// Scoreboard bench for reg_ctrl_sequencer: the driver issues instructions and
// pushes expected phase outputs; a negedge monitor pops and compares.
module tb_reg_ctrl_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_data = '0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = '0;
    logic [1:0]  rf_state;
    logic [2:0]  rf_enable;
    logic [2:0]  rf_sel;
    logic [3:0]  alu_op;
    logic [15:0] imm;
    logic        halted;

    always #5 clock = ~clock;

    reg_ctrl_sequencer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_valid    (imem_valid),
        .imem_data     (imem_data),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .rf_state      (rf_state),
        .rf_enable     (rf_enable),
        .rf_sel        (rf_sel),
        .alu_op        (alu_op),
        .imm           (imm),
        .halted        (halted)
    );

    typedef struct {
        int fetch_pc;
        int op;
        int wen;
        int rs1;
        int rs2;
        int imm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    int   model_pc = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: expected outputs from the instruction word, PC as plain integer arithmetic.
    task automatic push_expected(input int instr, input bit taken, input int target);
        exp_t e;
        int   imm6;
        e.fetch_pc = model_pc;
        e.op       = (instr >> 12) & 15;
        e.rs1      = (instr >> 6) & 7;
        e.rs2      = (instr >> 3) & 7;
        imm6       = instr & 63;
        e.imm      = (imm6 >= 32) ? imm6 + 65536 - 64 : imm6;
        e.wen      = (e.op >= 1 && e.op <= 11) ? ((instr >> 9) & 7) : 0;
        sb.push_back(e);
        if (e.op == 15) model_pc = model_pc;
        else if (e.op == 12 && taken) model_pc = target;
        else model_pc = (model_pc + 1) % 256;
    endtask

    task automatic issue(input int instr, input bit taken, input int target, input int idle);
        int budget = 0;
        @(negedge clock);
        while (!imem_req && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        chk("fetch_ready", int'(imem_req), 1);
        imem_valid = 1'b0;
        repeat (idle) begin
            imem_data = 16'($urandom);
            @(negedge clock);
        end
        imem_valid    = 1'b1;
        imem_data     = 16'(instr);
        branch_taken  = taken;
        branch_target = 8'(target);
        push_expected(instr, taken, target);
        @(negedge clock);
        imem_valid = 1'($urandom % 2);
        imem_data  = 16'($urandom);
        @(negedge clock);
        imem_valid = 1'($urandom % 2);
        imem_data  = 16'($urandom);
    endtask

    int prev_st = 0;
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_st = 0;
        end else begin
            case (int'(rf_state))
                0: begin
                    chk("fetch_prev", int'(prev_st == 0 || prev_st == 2), 1);
                    chk("fetch_req", int'(imem_req), 1);
                    chk("fetch_wen", int'(rf_enable), 0);
                    chk("fetch_halted", int'(halted), 0);
                end
                1: begin
                    chk("decode_prev", prev_st, 0);
                    chk("decode_sb_nonempty", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        chk("decode_addr", int'(imem_addr), sb[0].fetch_pc);
                        chk("decode_sel", int'(rf_sel), sb[0].rs1);
                        chk("decode_op", int'(alu_op), sb[0].op);
                        chk("decode_imm", int'(imm), sb[0].imm);
                        chk("decode_wen", int'(rf_enable), 0);
                        chk("decode_req", int'(imem_req), 0);
                    end
                end
                2: begin
                    chk("wb_prev", prev_st, 1);
                    chk("wb_sb_nonempty", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        chk("wb_wen", int'(rf_enable), sb[0].wen);
                        chk("wb_sel", int'(rf_sel), sb[0].rs2);
                        chk("wb_addr", int'(imem_addr), sb[0].fetch_pc);
                        void'(sb.pop_front());
                    end
                end
                default: begin
                    chk("halt_prev", int'(prev_st >= 2), 1);
                    chk("halt_flag", int'(halted), 1);
                    chk("halt_req", int'(imem_req), 0);
                    chk("halt_wen", int'(rf_enable), 0);
                end
            endcase
            prev_st = int'(rf_state);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int instr, op, budget;
        repeat (2) @(negedge clock);
        chk("rst_addr", int'(imem_addr), 0);
        chk("rst_req", int'(imem_req), 0);
        chk("rst_state", int'(rf_state), 0);
        chk("rst_wen", int'(rf_enable), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_imm", int'(imm), 0);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("rel_req", int'(imem_req), 1);
        chk("rel_addr", int'(imem_addr), 0);
        chk("rel_state", int'(rf_state), 0);

        issue(16'h1A4B, 1'b0, 0, 4);
        issue(16'h1060, 1'b1, 8'h33, 0);
        issue(16'hC03F, 1'b1, 8'h40, 1);
        issue(16'hC03F, 1'b0, 8'h80, 0);
        issue(16'hC03F, 1'b1, 8'hFF, 2);
        issue(16'h0000, 1'b1, 8'h12, 0);
        issue(16'hE1FF, 1'b1, 8'h20, 0);

        for (int i = 0; i < 250; i++) begin
            op    = (i % 5 == 0) ? 12 : int'($urandom_range(0, 14));
            instr = (op << 12) | int'($urandom & 32'hFFF);
            issue(instr, 1'($urandom % 2), int'($urandom % 256), int'($urandom_range(0, 3)));
        end

        issue(16'hF000, 1'b1, 8'h05, 0);
        repeat (10) begin
            imem_valid = 1'b1;
            imem_data  = 16'h1A4B;
            @(negedge clock);
            chk("halt_hold_state", int'(rf_state), 3);
            chk("halt_hold_pc", int'(imem_addr), model_pc);
        end
        chk("sb_drained_halt", sb.size(), 0);

        #1 reset_n = 1'b0;
        imem_valid = 1'b0;
        model_pc = 0;
        @(negedge clock);
        chk("rst2_state", int'(rf_state), 0);
        chk("rst2_halted", int'(halted), 0);
        chk("rst2_addr", int'(imem_addr), 0);
        #1 reset_n = 1'b1;

        budget = 0;
        @(negedge clock);
        while (!imem_req && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        chk("abort_fetch_ready", int'(imem_req), 1);
        imem_valid = 1'b1;
        imem_data  = 16'h1A4B;
        push_expected(16'h1A4B, 1'b0, 0);
        @(negedge clock);
        chk("abort_in_decode", int'(rf_state), 1);
        #1 reset_n = 1'b0;
        imem_valid = 1'b0;
        sb.delete();
        model_pc = 0;
        repeat (3) begin
            @(negedge clock);
            chk("abort_wen", int'(rf_enable), 0);
            chk("abort_state", int'(rf_state), 0);
            chk("abort_addr", int'(imem_addr), 0);
        end
        #1 reset_n = 1'b1;

        issue(16'h2292, 1'b0, 0, 1);
        issue(16'h0000, 1'b0, 0, 0);
        @(negedge clock);
        chk("sb_drained_end", sb.size(), 0);
        chk("end_addr", int'(imem_addr), 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
